// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for uart_tx_arbiter.
//   slave  : the arbiter's view (consumes requests and tx_busy, drives ack and tx_*)
//   master : the surroundings' view (requesters plus the UART transmitter)
// NUM_REQ must match the NUM_REQ of the arbiter this bundle is connected to.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ack;
    logic [7:0]           tx_data;
    logic                 tx_wr;
    logic                 tx_en;
    logic                 tx_busy;

    modport slave (
        input  req_valid, req_data, tx_busy,
        output req_ack, tx_data, tx_wr, tx_en
    );

    modport master (
        output req_valid, req_data, tx_busy,
        input  req_ack, tx_data, tx_wr, tx_en
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources.
// Optional start watchdog: define UART_TX_ARB_WATCHDOG_EN to abort a frame whose
// transmitter never reports busy within TIMEOUT cycles (sets the sticky err flag).
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_tx_arbiter_if.slave     bus,
    output logic [IDX_W-1:0]     grant_idx,
    output logic [15:0]          frames_sent,
    output logic                 err
);

    // Reject configurations the grant index or the 16-bit watchdog counter cannot cover.
    if ((NUM_REQ < 2) || ((2 ** IDX_W) < NUM_REQ) || (TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_bad_cfg
        $error("uart_tx_arbiter: unsupported NUM_REQ/IDX_W/TIMEOUT combination");
    end

    typedef enum logic [1:0] {
        IDLE,
        WAIT_START,
        WAIT_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_wr_q, tx_wr_d;
    logic               tx_en_q, tx_en_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic [15:0]        frames_sent_q, frames_sent_d;

`ifdef UART_TX_ARB_WATCHDOG_EN
    logic [15:0]        wd_cnt_q, wd_cnt_d;
    logic               err_q, err_d;
`endif

    logic               found;
    logic [IDX_W-1:0]   winner;
    logic [NUM_REQ-1:0] ack;

    // Round-robin search: first valid index above the last grant, then wrap to the bottom.
    always_comb begin
        found  = 1'b0;
        winner = grant_idx_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && bus.req_valid[i] && (i > 32'(grant_idx_q))) begin
                found  = 1'b1;
                winner = IDX_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && bus.req_valid[i] && (i <= 32'(grant_idx_q))) begin
                found  = 1'b1;
                winner = IDX_W'(i);
            end
        end
    end

    // Acknowledge the winner only while idle with the transmitter free.
    always_comb begin
        ack = '0;
        if ((state_q == IDLE) && !bus.tx_busy && found) begin
            ack = NUM_REQ'(1) << winner;
        end
    end

    // Next-state and next-output logic for the frame handshake.
    always_comb begin
        state_d       = state_q;
        tx_data_d     = tx_data_q;
        tx_wr_d       = tx_wr_q;
        tx_en_d       = tx_en_q;
        grant_idx_d   = grant_idx_q;
        frames_sent_d = frames_sent_q;
`ifdef UART_TX_ARB_WATCHDOG_EN
        wd_cnt_d      = wd_cnt_q;
        err_d         = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (|ack) begin
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        if (ack[i]) begin
                            tx_data_d = bus.req_data[i*8 +: 8];
                        end
                    end
                    grant_idx_d = winner;
                    tx_wr_d     = 1'b1;
                    tx_en_d     = 1'b1;
                    state_d     = WAIT_START;
`ifdef UART_TX_ARB_WATCHDOG_EN
                    wd_cnt_d    = '0;
`endif
                end
            end
            WAIT_START: begin
                if (bus.tx_busy) begin
                    tx_wr_d       = 1'b0;
                    frames_sent_d = frames_sent_q + 16'd1;
                    state_d       = WAIT_DONE;
                end
`ifdef UART_TX_ARB_WATCHDOG_EN
                // The counter holds the cycles already spent here; abort on the TIMEOUT-th.
                else if ((wd_cnt_q + 16'd1) == 16'(TIMEOUT)) begin
                    tx_wr_d = 1'b0;
                    tx_en_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 16'd1;
                end
`endif
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    tx_en_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                tx_wr_d = 1'b0;
                tx_en_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            tx_data_q     <= '0;
            tx_wr_q       <= 1'b0;
            tx_en_q       <= 1'b0;
            grant_idx_q   <= IDX_W'(NUM_REQ - 1);
            frames_sent_q <= '0;
`ifdef UART_TX_ARB_WATCHDOG_EN
            wd_cnt_q      <= '0;
            err_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            tx_data_q     <= tx_data_d;
            tx_wr_q       <= tx_wr_d;
            tx_en_q       <= tx_en_d;
            grant_idx_q   <= grant_idx_d;
            frames_sent_q <= frames_sent_d;
`ifdef UART_TX_ARB_WATCHDOG_EN
            wd_cnt_q      <= wd_cnt_d;
            err_q         <= err_d;
`endif
        end
    end

    assign bus.req_ack  = ack;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_wr    = tx_wr_q;
    assign bus.tx_en    = tx_en_q;
    assign grant_idx    = grant_idx_q;
    assign frames_sent  = frames_sent_q;
`ifdef UART_TX_ARB_WATCHDOG_EN
    assign err          = err_q;
`else
    assign err          = 1'b0;
`endif

endmodule
